// File: rtl/uart_rx_sampler.sv
// Bit timing and data capture for the uart_rx FSM: baud tick generation, centre sampling,
// LSB-first byte assembly, parity/stop checking. Define RX_MAJORITY_FILTER_EN for 2-of-3 glitch filtering.
module uart_rx_sampler #(
  parameter int BAUD_DIV   = 5208,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       enable_half,
  input  logic       enable_max,
  output logic       enable_flag,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_error,
  output logic       framing_error
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] TOP_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] TOP_FULL = CW'(BAUD_DIV - 1);

  logic [1:0]    sync;
  logic          rx_s;
  logic          sample;
  logic [CW-1:0] cnt;
  logic [CW-1:0] top;
  logic          counting;
  logic          bit_flag;
  logic          stop_flag;
  logic [3:0]    bidx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          start_bad;

  // Synchroniser idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rx};
  end
  assign rx_s = sync[1];

`ifdef RX_MAJORITY_FILTER_EN
  logic [2:0] hist;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hist <= 3'b111;
    else        hist <= {hist[1:0], rx_s};
  end
  assign sample = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
  assign sample = rx_s;
`endif

  assign counting    = enable_half | enable_max;
  assign top         = enable_half ? TOP_HALF : TOP_FULL;
  assign enable_flag = counting && (cnt == top);
  // enable_half wins if the FSM ever asserts both.
  assign bit_flag    = enable_flag & enable_max & ~enable_half;
  assign stop_flag   = bit_flag && (bidx == 4'd9);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      cnt <= '0;
    else if (!counting || enable_flag) cnt <= '0;
    else                             cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bidx      <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      start_bad <= 1'b0;
    end else begin
      if (enable_flag && enable_half) start_bad <= sample;
      if (!enable_max || enable_half) begin
        bidx <= '0;
      end else if (bit_flag) begin
        bidx <= bidx + 1'b1;
        if (bidx < 4'd8)       shreg   <= {sample, shreg[7:1]};
        else if (bidx == 4'd8) par_bit <= sample;
      end
    end
  end

  // Stop bit is judged straight from the sample so results land the cycle after its flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      rx_valid <= stop_flag;
      if (stop_flag) begin
        rx_data       <= shreg;
        parity_error  <= ((^shreg) ^ par_bit) != PARITY_ODD;
        framing_error <= start_bad | ~sample;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a small FSM model drives the enables, frames go through a scoreboard.
module tb_uart_rx_sampler;
  localparam int BD = 16;
  localparam int FRAME_CYC = 11 * BD - 8;  // rx timeline per frame; stop bit is shortened for back-to-back

  logic clk = 1'b0;
  logic reset;
  logic rx;
  logic enable_half, enable_max;
  logic enable_flag, enable_flag_odd;
  logic [7:0] rx_data, rx_data_odd;
  logic rx_valid, rx_valid_odd;
  logic parity_error, parity_error_odd;
  logic framing_error, framing_error_odd;

  always #5 clk = ~clk;

  uart_rx_sampler #(.BAUD_DIV(BD), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .reset(reset), .rx(rx), .enable_half(enable_half), .enable_max(enable_max),
    .enable_flag(enable_flag), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_error(parity_error), .framing_error(framing_error));

  uart_rx_sampler #(.BAUD_DIV(BD), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .rx(rx), .enable_half(enable_half), .enable_max(enable_max),
    .enable_flag(enable_flag_odd), .rx_data(rx_data_odd), .rx_valid(rx_valid_odd),
    .parity_error(parity_error_odd), .framing_error(framing_error_odd));

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       perr_odd;
    logic       ferr;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  // FSM model state: 0 idle, 1 start (half period), 2 data/parity/stop
  int   st = 0;
  int   nfl = 0;
  logic last_flag = 1'b0;
  logic start_req = 1'b0;
  logic abort_req = 1'b0;
  int   valid_cnt = 0;
  int   valid_with_half = 0;

  function automatic exp_t mk_exp(input logic [7:0] d, input logic p, input logic ferr);
    exp_t e;
    e.data     = d;
    e.perr     = ((^d) ^ p) != 1'b0;
    e.perr_odd = ((^d) ^ p) != 1'b1;
    e.ferr     = ferr;
    return e;
  endfunction

  // One clock: FSM reacts to last cycle's flag, drive rx, then sample outputs mid-cycle.
  task automatic step(input logic rx_val);
    exp_t e;
    @(posedge clk); #1;
    if (abort_req) begin
      st = 0;
      abort_req = 1'b0;
    end else if (last_flag) begin
      if (st == 1) begin
        st = 2;
        nfl = 0;
      end else if (st == 2) begin
        nfl++;
        if (nfl == 10) st = 0;
      end
    end
    if (start_req && st == 0) begin
      st = 1;
      start_req = 1'b0;
    end
    rx = rx_val;
    enable_half = (st == 1);
    enable_max  = (st == 2);
    @(negedge clk);
    last_flag = enable_flag;
    if (rx_valid) begin
      valid_cnt++;
      if (enable_half) valid_with_half++;
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_valid: rx_valid=1 with empty scoreboard, rx_data=%h", rx_data);
      end else begin
        e = sb.pop_front();
        if ({rx_data, parity_error, parity_error_odd, framing_error, rx_valid_odd} !==
            {e.data, e.perr, e.perr_odd, e.ferr, 1'b1}) begin
          mismatched++;
          $display("FAIL frame: got data=%h perr=%b perr_odd=%b ferr=%b valid_odd=%b, expected data=%h perr=%b perr_odd=%b ferr=%b",
                   rx_data, parity_error, parity_error_odd, framing_error, rx_valid_odd,
                   e.data, e.perr, e.perr_odd, e.ferr);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // start_ok=0 makes a one-cycle low pulse so the start bit samples high.
  task automatic drive_frame(input logic [7:0] d, input logic p, input logic s, input logic start_ok,
                             input int glitch_t, input int abort_t);
    logic v;
    int   bi;
    for (int t = 0; t < FRAME_CYC; t++) begin
      if (t == 2) start_req = 1'b1;
      if (t == abort_t) abort_req = 1'b1;
      bi = t / BD;
      if (t == 0)      v = 1'b0;
      else if (bi == 0) v = ~start_ok;
      else if (bi <= 8) v = d[bi-1];
      else if (bi == 9) v = p;
      else              v = s;
      if (t == glitch_t) v = ~v;
      step(v);
      if (abort_t >= 0 && t == abort_t + 1) begin
        compared++;
        if ({dut.cnt, dut.bidx, rx_valid} !== '0) begin
          mismatched++;
          $display("FAIL abort_clear: cnt=%0d bidx=%0d rx_valid=%b, expected 0 0 0", dut.cnt, dut.bidx, rx_valid);
        end
      end
    end
  endtask

  task automatic check_drained(input string name);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL %s_missing_valid: %0d frames outstanding, expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx = 1'b1;
    enable_half = 1'b0;
    enable_max = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({enable_flag, rx_valid, rx_data, parity_error, framing_error} !== 12'h0) begin
      mismatched++;
      $display("FAIL reset: flag=%b valid=%b data=%h perr=%b ferr=%b, expected all 0",
               enable_flag, rx_valid, rx_data, parity_error, framing_error);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_timing();
    logic exp_flag;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      enable_half = (c < 8);
      enable_max  = (c >= 8);
      @(negedge clk);
      exp_flag = (c == 7) || (c == 23) || (c == 39) || (c == 55);
      compared++;
      if (enable_flag !== exp_flag) begin
        mismatched++;
        $display("FAIL timing_cycle%0d: enable_flag=%b, expected %b", c, enable_flag, exp_flag);
      end
    end
    @(posedge clk); #1;
    enable_half = 1'b0;
    enable_max = 1'b0;
    last_flag = 1'b0;
    idle(3);
  endtask

  task automatic test_parity();
    sb.push_back(mk_exp(8'hA5, 1'b0, 1'b0));
    drive_frame(8'hA5, 1'b0, 1'b1, 1'b1, -1, -1);
    idle(8);
    sb.push_back(mk_exp(8'hA5, 1'b1, 1'b0));
    drive_frame(8'hA5, 1'b1, 1'b1, 1'b1, -1, -1);
    idle(8);
    check_drained("parity");
  endtask

  task automatic test_framing();
    sb.push_back(mk_exp(8'h3C, 1'b0, 1'b1));
    drive_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1, -1);
    idle(8);
    sb.push_back(mk_exp(8'hFF, 1'b1, 1'b1));
    drive_frame(8'hFF, 1'b1, 1'b1, 1'b0, -1, -1);
    idle(8);
    check_drained("framing");
  endtask

  task automatic test_abort();
    int vc;
    vc = valid_cnt;
    // B3 flag lands at cycle 73; cycle 80 is mid-B4.
    drive_frame(8'h55, 1'b0, 1'b1, 1'b1, -1, 80);
    idle(8);
    compared++;
    if (valid_cnt != vc || rx_data !== 8'hFF || framing_error !== 1'b1) begin
      mismatched++;
      $display("FAIL abort_hold: valids=%0d data=%h ferr=%b, expected 0 new valids data=ff ferr=1",
               valid_cnt - vc, rx_data, framing_error);
    end
    sb.push_back(mk_exp(8'h81, 1'b0, 1'b0));
    drive_frame(8'h81, 1'b0, 1'b1, 1'b1, -1, -1);
    idle(8);
    check_drained("abort");
  endtask

  task automatic test_glitch();
    int gt;
    // rx_s lags rx by two cycles, so this lands the glitch exactly on the B2 sample.
    gt = 2 + BD / 2 - 1 + BD * 3 - 2;
`ifdef RX_MAJORITY_FILTER_EN
    sb.push_back(mk_exp(8'h00, 1'b0, 1'b0));
`else
    sb.push_back(mk_exp(8'h04, 1'b0, 1'b0));
`endif
    drive_frame(8'h00, 1'b0, 1'b1, 1'b1, gt, -1);
    idle(8);
    check_drained("glitch");
  endtask

  task automatic test_back_to_back();
    int vh;
    vh = valid_with_half;
    sb.push_back(mk_exp(8'h5A, 1'b0, 1'b0));
    drive_frame(8'h5A, 1'b0, 1'b1, 1'b1, -1, -1);
    sb.push_back(mk_exp(8'hC3, 1'b0, 1'b0));
    drive_frame(8'hC3, 1'b0, 1'b1, 1'b1, -1, -1);
    idle(8);
    check_drained("b2b");
    compared++;
    if (valid_with_half - vh != 1) begin
      mismatched++;
      $display("FAIL b2b_overlap: %0d valids overlapped enable_half, expected 1", valid_with_half - vh);
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_parity();
    test_framing();
    test_abort();
    test_glitch();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
